// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared encodings and width defaults for the memory arbiter
package unified_mem_arbiter_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_WAIT = 2'd1,
      D_WAIT = 2'd2
   } arb_state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } grant_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter for a single multi-cycle unified memory port
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_kill,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall_f,
   output logic              stall_m
);

   arb_state_t        state, state_nxt;
   grant_t            last_grant, last_grant_nxt;
   logic              kill_pend, kill_pend_nxt;
   logic              mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;
   logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
   logic              i_valid_nxt, d_valid_nxt;
   logic              i_elig, d_elig;

   // A requester in its valid cycle is consuming the result, not asking again.
   assign i_elig  = i_req & ~i_valid;
   assign d_elig  = d_req & ~d_valid;
   assign stall_f = i_elig;
   assign stall_m = d_elig;
   assign mem_req = (state != IDLE);

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      kill_pend_nxt  = kill_pend;
      mem_we_nxt     = mem_we;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      i_rdata_nxt    = i_rdata;
      d_rdata_nxt    = d_rdata;
      i_valid_nxt    = 1'b0;
      d_valid_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (d_elig && (!i_elig || last_grant != DATA)) begin
               state_nxt      = D_WAIT;
               last_grant_nxt = DATA;
               mem_we_nxt     = d_we;
               mem_addr_nxt   = d_addr;
               mem_wdata_nxt  = d_wdata;
            end else if (i_elig) begin
               state_nxt      = I_WAIT;
               last_grant_nxt = FETCH;
               mem_we_nxt     = 1'b0;
               mem_addr_nxt   = i_addr;
               kill_pend_nxt  = i_kill;
            end
         end
         I_WAIT: begin
            // Memory cannot be cancelled, so a killed fetch still runs to mem_ready.
            if (mem_ready) begin
               i_rdata_nxt   = mem_rdata;
               i_valid_nxt   = ~(kill_pend | i_kill);
               kill_pend_nxt = 1'b0;
               state_nxt     = IDLE;
            end else if (i_kill) begin
               kill_pend_nxt = 1'b1;
            end
         end
         D_WAIT: begin
            if (mem_ready) begin
               d_rdata_nxt = mem_rdata;
               d_valid_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= FETCH;
         kill_pend  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_valid    <= 1'b0;
         d_valid    <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         kill_pend  <= kill_pend_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         i_rdata    <= i_rdata_nxt;
         d_rdata    <= d_rdata_nxt;
         i_valid    <= i_valid_nxt;
         d_valid    <= d_valid_nxt;
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_kill = 1'b0;
   logic [31:0] i_rdata;
   logic        i_valid;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        stall_f;
   logic        stall_m;

   int total = 0;
   int bad = 0;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_rdata(i_rdata), .i_valid(i_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_f(stall_f), .stall_m(stall_m)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%h exp=0", mem_req); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%h exp=0", mem_we); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
      total++; if (i_valid !== 1'b0 || d_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b%b exp=00", i_valid, d_valid); end
      total++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", i_rdata, d_rdata); end
      total++; if (stall_f !== 1'b0 || stall_m !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b%b exp=00", stall_f, stall_m); end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_fetch();
      tick();
      i_req = 1'b1; i_addr = 32'h40;
      @(negedge clk);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_pre_req got=%h exp=0", mem_req); end
      total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL fetch_pre_stall got=%h exp=1", stall_f); end
      for (int c = 0; c < 3; c++) begin
         tick();
         mem_ready = (c == 2); mem_rdata = 32'h00500093;
         @(negedge clk);
         total++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0)
            begin bad++; $display("FAIL fetch_hold c=%0d got req=%h addr=%h we=%h exp 1/40/0", c, mem_req, mem_addr, mem_we); end
         total++; if (i_valid !== 1'b0 || stall_f !== 1'b1)
            begin bad++; $display("FAIL fetch_wait c=%0d got valid=%h stall=%h exp 0/1", c, i_valid, stall_f); end
      end
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      total++; if (i_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%h exp=1", i_valid); end
      total++; if (i_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_rdata got=%h exp=00500093", i_rdata); end
      total++; if (stall_f !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL fetch_done got stall=%h req=%h exp 0/0", stall_f, mem_req); end
      tick();
      i_req = 1'b0;
      @(negedge clk);
      total++; if (i_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL fetch_once got valid=%h req=%h exp 0/0", i_valid, mem_req); end
   endtask

   task automatic test_contention();
      tick();
      i_req = 1'b1; i_addr = 32'h44;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      mem_ready = 1'b1; mem_rdata = 32'hA1;
      tick();
      @(negedge clk);
      total++; if (mem_addr !== 32'h100 || mem_req !== 1'b1) begin bad++; $display("FAIL cont_first_data got addr=%h req=%h exp 100/1", mem_addr, mem_req); end
      total++; if (stall_f !== 1'b1 || stall_m !== 1'b1) begin bad++; $display("FAIL cont_stalls got=%b%b exp=11", stall_f, stall_m); end
      tick();
      d_addr = 32'h104; mem_rdata = 32'hB2;
      @(negedge clk);
      total++; if (d_valid !== 1'b1 || d_rdata !== 32'hA1) begin bad++; $display("FAIL cont_d1 got valid=%h rdata=%h exp 1/a1", d_valid, d_rdata); end
      total++; if (stall_m !== 1'b0 || stall_f !== 1'b1) begin bad++; $display("FAIL cont_d1_stall got m=%h f=%h exp 0/1", stall_m, stall_f); end
      tick();
      @(negedge clk);
      total++; if (mem_addr !== 32'h44 || mem_we !== 1'b0) begin bad++; $display("FAIL cont_second_fetch got addr=%h we=%h exp 44/0", mem_addr, mem_we); end
      tick();
      i_addr = 32'h48; mem_rdata = 32'hC3;
      @(negedge clk);
      total++; if (i_valid !== 1'b1 || i_rdata !== 32'hB2) begin bad++; $display("FAIL cont_i1 got valid=%h rdata=%h exp 1/b2", i_valid, i_rdata); end
      tick();
      @(negedge clk);
      total++; if (mem_addr !== 32'h104) begin bad++; $display("FAIL cont_third_data got addr=%h exp=104", mem_addr); end
      tick();
      d_req = 1'b0; mem_rdata = 32'hD4;
      @(negedge clk);
      total++; if (d_valid !== 1'b1 || d_rdata !== 32'hC3) begin bad++; $display("FAIL cont_d2 got valid=%h rdata=%h exp 1/c3", d_valid, d_rdata); end
      tick();
      @(negedge clk);
      total++; if (mem_addr !== 32'h48) begin bad++; $display("FAIL cont_fourth_fetch got addr=%h exp=48", mem_addr); end
      tick();
      i_req = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      total++; if (i_valid !== 1'b1 || i_rdata !== 32'hD4) begin bad++; $display("FAIL cont_i2 got valid=%h rdata=%h exp 1/d4", i_valid, i_rdata); end
      tick();
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || i_valid !== 1'b0) begin bad++; $display("FAIL cont_end got req=%h valid=%h exp 0/0", mem_req, i_valid); end
   endtask

   task automatic test_store();
      tick();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
      @(negedge clk);
      total++; if (mem_req !== 1'b0 || stall_m !== 1'b1) begin bad++; $display("FAIL st_pre got req=%h stall=%h exp 0/1", mem_req, stall_m); end
      tick();
      d_wdata = 32'h12345678; mem_ready = 1'b1; mem_rdata = 32'h0;
      @(negedge clk);
      total++; if (mem_we !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL st_latch got we=%h addr=%h exp 1/200", mem_we, mem_addr); end
      total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL st_wdata_hold got=%h exp=deadbeef", mem_wdata); end
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      total++; if (d_valid !== 1'b1 || stall_m !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL st_valid got valid=%h stall=%h req=%h exp 1/0/0", d_valid, stall_m, mem_req); end
      tick();
      d_req = 1'b0;
      @(negedge clk);
      total++; if (d_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL st_once got valid=%h req=%h exp 0/0", d_valid, mem_req); end
      tick();
      i_req = 1'b1; i_addr = 32'h60;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      mem_ready = 1'b1; mem_rdata = 32'h77;
      tick();
      @(negedge clk);
      total++; if (mem_addr !== 32'h60 || mem_we !== 1'b0) begin bad++; $display("FAIL st_fairness got addr=%h we=%h exp 60/0", mem_addr, mem_we); end
      tick();
      i_req = 1'b0; mem_rdata = 32'h88;
      @(negedge clk);
      total++; if (i_valid !== 1'b1 || i_rdata !== 32'h77) begin bad++; $display("FAIL st_fair_i got valid=%h rdata=%h exp 1/77", i_valid, i_rdata); end
      tick();
      @(negedge clk);
      total++; if (mem_addr !== 32'h300 || mem_we !== 1'b0) begin bad++; $display("FAIL st_fair_d got addr=%h we=%h exp 300/0", mem_addr, mem_we); end
      tick();
      d_req = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      total++; if (d_valid !== 1'b1 || d_rdata !== 32'h88) begin bad++; $display("FAIL st_fair_dv got valid=%h rdata=%h exp 1/88", d_valid, d_rdata); end
   endtask

   task automatic test_kill();
      tick();
      i_req = 1'b1; i_addr = 32'h70;
      @(negedge clk);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL kill_pre got req=%h exp 0", mem_req); end
      tick();
      i_kill = 1'b1;
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h70) begin bad++; $display("FAIL kill_grant got req=%h addr=%h exp 1/70", mem_req, mem_addr); end
      tick();
      i_kill = 1'b0; i_addr = 32'h80;
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h70) begin bad++; $display("FAIL kill_hold1 got req=%h addr=%h exp 1/70", mem_req, mem_addr); end
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hBAD;
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || i_valid !== 1'b0) begin bad++; $display("FAIL kill_hold2 got req=%h valid=%h exp 1/0", mem_req, i_valid); end
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      total++; if (i_valid !== 1'b0) begin bad++; $display("FAIL kill_dropped got valid=%h exp 0", i_valid); end
      total++; if (mem_req !== 1'b0 || stall_f !== 1'b1) begin bad++; $display("FAIL kill_idle got req=%h stall=%h exp 0/1", mem_req, stall_f); end
      tick();
      mem_ready = 1'b1; mem_rdata = 32'h13;
      @(negedge clk);
      total++; if (mem_addr !== 32'h80 || mem_req !== 1'b1 || i_valid !== 1'b0) begin bad++; $display("FAIL kill_refetch got addr=%h req=%h valid=%h exp 80/1/0", mem_addr, mem_req, i_valid); end
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      total++; if (i_valid !== 1'b1 || i_rdata !== 32'h13) begin bad++; $display("FAIL kill_refetch_valid got valid=%h rdata=%h exp 1/13", i_valid, i_rdata); end
      tick();
      i_req = 1'b0;
      @(negedge clk);
      total++; if (i_valid !== 1'b0) begin bad++; $display("FAIL kill_end got valid=%h exp 0", i_valid); end
   endtask

   task automatic test_reset_mid();
      tick();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      tick();
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin bad++; $display("FAIL rmid_pre got req=%h addr=%h exp 1/400", mem_req, mem_addr); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL rmid_req got req=%h we=%h exp 0/0", mem_req, mem_we); end
      total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rmid_mem got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata); end
      total++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rmid_rdata got=%h/%h exp 0/0", i_rdata, d_rdata); end
      total++; if (i_valid !== 1'b0 || d_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b%b exp 00", i_valid, d_valid); end
      tick();
      rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h55;
      @(negedge clk);
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmid_idle got req=%h exp 0", mem_req); end
      tick();
      @(negedge clk);
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin bad++; $display("FAIL rmid_regrant got req=%h addr=%h exp 1/400", mem_req, mem_addr); end
      tick();
      d_req = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      total++; if (d_valid !== 1'b1 || d_rdata !== 32'h55) begin bad++; $display("FAIL rmid_load got valid=%h rdata=%h exp 1/55", d_valid, d_rdata); end
   endtask

   task automatic test_ready_idle();
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hFF; i_kill = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         @(negedge clk);
         total++; if (i_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0)
            begin bad++; $display("FAIL ridle c=%0d got iv=%h dv=%h req=%h exp 0/0/0", c, i_valid, d_valid, mem_req); end
      end
      total++; if (d_rdata !== 32'h55) begin bad++; $display("FAIL ridle_hold got=%h exp=55", d_rdata); end
      tick();
      mem_ready = 1'b0; i_kill = 1'b0;
      i_req = 1'b1; i_addr = 32'h90;
      tick();
      mem_ready = 1'b1; mem_rdata = 32'h99;
      @(negedge clk);
      total++; if (mem_addr !== 32'h90 || mem_req !== 1'b1) begin bad++; $display("FAIL ridle_fetch got addr=%h req=%h exp 90/1", mem_addr, mem_req); end
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      total++; if (i_valid !== 1'b1 || i_rdata !== 32'h99) begin bad++; $display("FAIL ridle_fetch_valid got valid=%h rdata=%h exp 1/99", i_valid, i_rdata); end
      tick();
      i_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_contention();
      test_store();
      test_kill();
      test_reset_mid();
      test_ready_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
